// File: rtl/pwm_pkg.sv
// pwm_pkg
// Shared definitions for the red-channel PWM duty control slice.
//   CBITS_DEF    : default PWM counter width (one period = 2^CBITS cycles)
//   DUTY_W       : width of the duty level handed to the PWM generator
//   DUTY_MAX     : highest duty level
//   duty_state_t : ramp state (SETTLED, UP, DOWN)
package pwm_pkg;

  localparam int CBITS_DEF = 14;
  localparam int DUTY_W    = 3;
  localparam logic [DUTY_W-1:0] DUTY_MAX = '1;

  typedef enum logic [1:0] {
    SETTLED = 2'd0,
    UP      = 2'd1,
    DOWN    = 2'd2
  } duty_state_t;

endpackage

// File: rtl/sw_debounce.sv
// sw_debounce
// One switch bit: 2-FF synchroniser followed by a debouncer. The debounced
// output takes the synchronised value once it has differed from the current
// debounced value for DEB_CYCLES consecutive cycles; any bounce back to the
// current value restarts the count.
// Ports:
//   clk   : clock
//   rst_n : asynchronous active-low reset
//   raw   : raw asynchronous switch input
//   deb   : debounced, synchronous switch value
module sw_debounce #(
  parameter int DEB_CYCLES = 50000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic deb
);

  localparam int CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

  if (DEB_CYCLES < 1) begin : g_deb_chk
    $error("sw_debounce: DEB_CYCLES must be at least 1");
  end

  logic          sync_p0;
  logic          sync_p1;
  logic [CW-1:0] cnt;

  // Stage p0/p1: metastability synchroniser, then the stability counter.
  // The counter holds the number of cycles already seen with a difference,
  // so the update fires on the DEB_CYCLES-th differing cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
      cnt     <= '0;
      deb     <= 1'b0;
    end else begin
      sync_p0 <= raw;
      sync_p1 <= sync_p0;
      if (sync_p1 != deb) begin
        if (cnt == CNT_LAST) begin
          deb <= sync_p1;
          cnt <= '0;
        end else begin
          cnt <= cnt + CW'(1);
        end
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/pwm_duty_ctrl.sv
// pwm_duty_ctrl
// Control stage ahead of the red-channel PWM generator. Debounces the four
// board switches, derives a 3-bit target level (sw[0] enables, sw[3:1] is
// the level) and moves duty_lvl toward it only on PWM period boundaries.
//
// Build option:
//   DUTY_RAMP_EN defined   : duty_lvl steps one LSB every RAMP_PERIODS
//                            boundaries toward the target.
//   DUTY_RAMP_EN undefined : duty_lvl loads the target at every boundary.
//
// Ports:
//   clk          : clock, all state on posedge
//   rst_n        : asynchronous active-low reset
//   sw[3:0]      : raw switches, sw[0] = enable, sw[3:1] = requested level
//   duty_lvl     : current duty level (registered)
//   period_start : one-cycle pulse on the first cycle of each PWM period
//   busy         : high while duty_lvl differs from the target
module pwm_duty_ctrl
  import pwm_pkg::*;
#(
  parameter int CBITS        = CBITS_DEF,
  parameter int DEB_CYCLES   = 50000,
  parameter int RAMP_PERIODS = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [3:0]        sw,
  output logic [DUTY_W-1:0] duty_lvl,
  output logic              period_start,
  output logic              busy
);

  if (RAMP_PERIODS < 1) begin : g_ramp_chk
    $error("pwm_duty_ctrl: RAMP_PERIODS must be at least 1");
  end

  // Saturating one-LSB step; the level never wraps.
  function automatic logic [DUTY_W-1:0] sat_step(input logic [DUTY_W-1:0] lvl,
                                                 input logic              up);
    if (up) return (lvl == DUTY_MAX) ? lvl : lvl + DUTY_W'(1);
    else    return (lvl == '0)       ? lvl : lvl - DUTY_W'(1);
  endfunction

  logic [3:0]        sw_deb;
  logic [DUTY_W-1:0] target;
  logic [CBITS-1:0]  pcnt;
  logic              boundary;
  logic [DUTY_W-1:0] duty_next;

  for (genvar i = 0; i < 4; i++) begin : g_sw
    sw_debounce #(
      .DEB_CYCLES (DEB_CYCLES)
    ) u_deb (
      .clk   (clk),
      .rst_n (rst_n),
      .raw   (sw[i]),
      .deb   (sw_deb[i])
    );
  end

  assign target   = sw_deb[0] ? sw_deb[3:1] : '0;
  // The edge on which the counter wraps is the period boundary.
  assign boundary = (pcnt == '1);

  // Stage p0: free-running period counter and period_start pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pcnt         <= '0;
      period_start <= 1'b0;
    end else begin
      pcnt         <= pcnt + CBITS'(1);
      period_start <= boundary;
    end
  end

`ifdef DUTY_RAMP_EN
  localparam int SCW = (RAMP_PERIODS > 1) ? $clog2(RAMP_PERIODS) : 1;
  localparam logic [SCW-1:0] STEP_LAST = SCW'(RAMP_PERIODS - 1);

  duty_state_t    state;
  duty_state_t    state_next;
  logic [SCW-1:0] step_cnt;
  logic [SCW-1:0] step_next;
  logic           wrong_side;

  // Target now lies on the other side of duty_lvl than the ramp direction.
  assign wrong_side = (target > duty_lvl) != (state == UP);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= SETTLED;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (boundary) begin
      case (state)
        SETTLED: begin
          if (target > duty_lvl)      state_next = UP;
          else if (target < duty_lvl) state_next = DOWN;
        end
        UP, DOWN: begin
          if (target == duty_lvl)  state_next = SETTLED;
          else if (wrong_side)     state_next = (state == UP) ? DOWN : UP;
          else if (step_cnt == STEP_LAST &&
                   sat_step(duty_lvl, state == UP) == target)
                                   state_next = SETTLED;
        end
        default: state_next = SETTLED;
      endcase
    end
  end

  always_comb begin
    duty_next = duty_lvl;
    step_next = step_cnt;
    if (boundary) begin
      case (state)
        UP, DOWN: begin
          if (target == duty_lvl || wrong_side) begin
            step_next = '0;
          end else if (step_cnt == STEP_LAST) begin
            duty_next = sat_step(duty_lvl, state == UP);
            step_next = '0;
          end else begin
            step_next = step_cnt + SCW'(1);
          end
        end
        default: step_next = '0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) step_cnt <= '0;
    else        step_cnt <= step_next;
  end
`else
  always_comb begin
    duty_next = boundary ? target : duty_lvl;
  end
`endif

  // Stage p1: duty level and busy flag updated from the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      duty_lvl <= '0;
      busy     <= 1'b0;
    end else begin
      duty_lvl <= duty_next;
      busy     <= (duty_next != target);
    end
  end

endmodule
